// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial multiword adder.
package add_seq_pkg;

  // Width of the shared datapath adder.
  localparam int unsigned NibbleW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/four_bit_adder.sv
// Combinational 4-bit ripple adder with carry in and carry out.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Full 5-bit result so the carry out falls out of the top bit.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Multiword adder that reuses one 4-bit adder over NIBBLES cycles, least-significant
// nibble first. Ready/valid on both sides; one operation in flight at a time.
// Optional signed-overflow output is built when ADD_SEQ_OVF_EN is defined.
module multiword_add_seq
  import add_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NibbleW*NIBBLES-1:0] a,
  input  logic [NibbleW*NIBBLES-1:0] b,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NibbleW*NIBBLES-1:0] sum,
  output logic                       cout,
  output logic                       busy
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic                       ovf
`endif
);

  localparam int unsigned W       = NibbleW * NIBBLES;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
`ifdef ADD_SEQ_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [NibbleW-1:0] nib_a, nib_b, add_sum;
  logic               add_cout;
  logic               msb_cin;

  // Operand nibbles are muxed out of the latched words by the current index.
  always_comb begin
    nib_a = a_q[NibbleW*idx_q +: NibbleW];
    nib_b = b_q[NibbleW*idx_q +: NibbleW];
  end

  four_bit_adder u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Carry into the top bit of this nibble, recovered from its sum bit.
  assign msb_cin = nib_a[NibbleW-1] ^ nib_b[NibbleW-1] ^ add_sum[NibbleW-1];

  // Next-state logic for the controller and the datapath registers.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef ADD_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          cout_d  = 1'b0;
`ifdef ADD_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[NibbleW*idx_q +: NibbleW] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          cout_d  = add_cout;
`ifdef ADD_SEQ_OVF_EN
          ovf_d   = msb_cin ^ add_cout;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // All state, cleared asynchronously so a reset mid-operation discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef ADD_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef ADD_SEQ_OVF_EN
  assign ovf       = ovf_q;
`else
  // Carry into the MSB is only consumed by the overflow flag.
  logic unused_msb_cin;
  assign unused_msb_cin = msb_cin;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq (NIBBLES=4): the driver queues the expected
// result for each operation, a negedge monitor checks whatever the DUT presents.
module tb_multiword_add_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
`ifdef ADD_SEQ_OVF_EN
  logic        ovf;
`endif

  int tests;
  int fails;
  int cyc;

  // Expected entries: {ovf, cout, sum}
  logic [17:0] sb_q[$];

  multiword_add_seq #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef ADD_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: retires results against the scoreboard and checks timing/hold properties.
  logic        prev_valid;
  logic        prev_ready;
  logic [15:0] prev_sum;
  logic        prev_cout;
  int          acc_cyc;

  initial begin
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    prev_sum   = '0;
    prev_cout  = 1'b0;
    acc_cyc    = 0;
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) chk("latency", cyc - acc_cyc, 4);
      if (out_valid) chk("in_ready_low_in_done", {31'd0, in_ready}, 0);
      if (out_valid && prev_valid && !prev_ready) begin
        chk("hold_sum", {16'd0, sum}, {16'd0, prev_sum});
        chk("hold_cout", {31'd0, cout}, {31'd0, prev_cout});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sum", {16'd0, sum}, {16'd0, e[15:0]});
          chk("cout", {31'd0, cout}, {31'd0, e[16]});
`ifdef ADD_SEQ_OVF_EN
          chk("ovf", {31'd0, ovf}, {31'd0, e[17]});
`endif
        end
      end
      if (in_valid && in_ready) acc_cyc = cyc + 1;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
    end
  end

  // Inputs change 1ns after the rising edge, well clear of both sampling points.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation and returns just after the accept edge.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                       input bit push, input logic [17:0] exp,
                       input bit scramble, input bit keep_valid);
    int n;
    if (push) sb_q.push_back(exp);
    a = ta;
    b = tb_;
    cin = tc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 1, 0);
    step();
    if (!keep_valid) in_valid = 1'b0;
    if (scramble) begin
      a = 16'hAAAA;
      b = 16'hAAAA;
      cin = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain", sb_q.size(), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_sum", {16'd0, sum}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
`ifdef ADD_SEQ_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 0);
`endif
    step();
    rst_n = 1'b1;

    // Basic directed vectors.
    issue(16'h0000, 16'h0000, 1'b0, 1, {1'b0, 1'b0, 16'h0000}, 0, 0);
    drain();
    issue(16'hFFFF, 16'h0001, 1'b0, 1, {1'b0, 1'b1, 16'h0000}, 0, 0);
    drain();
    issue(16'h1234, 16'h4321, 1'b1, 1, {1'b0, 1'b0, 16'h5556}, 1, 0);
    drain();
    issue(16'h7FFF, 16'h0001, 1'b0, 1, {1'b1, 1'b0, 16'h8000}, 0, 0);
    drain();
    issue(16'h8000, 16'h8000, 1'b0, 1, {1'b1, 1'b1, 16'h0000}, 0, 0);
    drain();
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1, {1'b0, 1'b1, 16'hFFFF}, 0, 0);
    drain();

    // Back-pressure: result held 5 cycles with in_valid kept high.
    out_ready = 1'b0;
    issue(16'h00FF, 16'h0F01, 1'b0, 1, {1'b0, 1'b0, 16'h1000}, 0, 1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        step();
        n++;
      end
      chk("stall_out_valid", {31'd0, out_valid}, 1);
    end
    repeat (5) step();
    chk("stall_busy", {31'd0, busy}, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("idle_after_retire", {31'd0, in_ready}, 1);

    // Reset in the middle of RUN discards the operation.
    issue(16'h1111, 16'h2222, 1'b0, 0, '0, 0, 0);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_sum", {16'd0, sum}, 0);
    step();
    rst_n = 1'b1;
    repeat (6) step();
    issue(16'h000F, 16'h0001, 1'b0, 1, {1'b0, 1'b0, 16'h0010}, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
